// File: rtl/cpu_clk_ctrl_if.sv
// Signal bundle between the board-level controls and the CPU clock generator.
// The master side drives the raw button, mode switch and divide select; the
// slave side (the clock generator) returns the CPU clock and its debug outputs.
interface cpu_clk_ctrl_if;
   logic        step_btn;
   logic        mode_auto;
   logic [4:0]  div_sel;
   logic        cpu_clk;
   logic        cpu_clk_rise;
   logic [15:0] rise_count;

   modport master (
      output step_btn,
      output mode_auto,
      output div_sel,
      input  cpu_clk,
      input  cpu_clk_rise,
      input  rise_count
   );

   modport slave (
      input  step_btn,
      input  mode_auto,
      input  div_sel,
      output cpu_clk,
      output cpu_clk_rise,
      output rise_count
   );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock generator: free-running divide-by-2^(div_sel+1) or single-step,
// one full CPU clock period per debounced button press. cpu_clk is a fabric
// clock driven from a flop; rise_count feeds the debug display.
module cpu_clk_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES  = 500000,
   parameter int unsigned STEP_HIGH_CYCLES = 4,
   parameter int unsigned CNT_WIDTH        = 24
) (
   input logic           clk,
   input logic           rst,
   cpu_clk_ctrl_if.slave bus
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]      DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] STEP_LAST = CNT_WIDTH'(STEP_HIGH_CYCLES - 1);
   // CNT_WIDTH is assumed to be at most 32 so the largest select fits in 5 bits
   localparam logic [4:0]           SEL_MAX   = 5'(CNT_WIDTH - 1);

   typedef enum logic {S_LOW, S_HIGH} state_t;

   // Bit 0 = step button, bit 1 = mode switch
   logic [1:0]           raw;
   logic [1:0]           sync1;
   logic [1:0]           sync2;
   logic [1:0]           deb;
   logic [1:0][DB_W-1:0] db_cnt;
   logic [1:0]           deb_flip;
   logic                 press;

   logic [4:0]           sel_sat;
   logic [CNT_WIDTH-1:0] half_last;
   logic [CNT_WIDTH-1:0] high_last;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] half_cnt_q, half_cnt_d;
   logic                 pending_q, pending_d;
   logic                 active_q, active_d;
   logic                 cpu_clk_q, cpu_clk_d;
   logic                 rise_q, rise_d;
   logic [15:0]          count_q, count_d;

   assign raw = {bus.mode_auto, bus.step_btn};

   // Two-flop synchronisers for the asynchronous button and switch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Flip a debounced level once the synchronised sample has disagreed long enough
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_flip[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST);
      end
      press = deb_flip[0] & ~deb[0];
   end

   // Per-input debounce counter and debounced level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb    <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (deb_flip[i]) begin
               deb[i]    <= ~deb[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Saturated divide select and the terminal half-period count per phase
   always_comb begin
      sel_sat   = (bus.div_sel > SEL_MAX) ? SEL_MAX : bus.div_sel;
      half_last = (CNT_WIDTH'(1) << sel_sat) - CNT_WIDTH'(1);
      high_last = active_q ? half_last : STEP_LAST;
   end

   // Next-state logic for the low/high phase machine and its outputs
   always_comb begin
      state_d    = state_q;
      half_cnt_d = half_cnt_q;
      pending_d  = pending_q | press;
      active_d   = active_q;
      rise_d     = 1'b0;
      count_d    = count_q;

      unique case (state_q)
         S_LOW: begin
            // Mode may only change while low, so a high phase is never cut short
            active_d = deb[1];
            if (active_q) begin
               // >= so a div_sel decrease mid-phase cannot strand the counter
               if (half_cnt_q >= half_last) begin
                  half_cnt_d = '0;
                  state_d    = S_HIGH;
               end else begin
                  half_cnt_d = half_cnt_q + CNT_WIDTH'(1);
               end
            end else begin
               half_cnt_d = '0;
               if (pending_q) begin
                  state_d   = S_HIGH;
                  pending_d = 1'b0;
               end
            end
         end
         S_HIGH: begin
            if (half_cnt_q >= high_last) begin
               half_cnt_d = '0;
               state_d    = S_LOW;
            end else begin
               half_cnt_d = half_cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d    = S_LOW;
            half_cnt_d = '0;
         end
      endcase

      // Presses seen while free-running must not fire on entry to step mode
      if (active_q) begin
         pending_d = 1'b0;
      end

      if (state_q == S_LOW && state_d == S_HIGH) begin
         rise_d  = 1'b1;
         count_d = count_q + 16'd1;
      end

      cpu_clk_d = (state_d == S_HIGH);
   end

   // Phase machine state, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_LOW;
         half_cnt_q <= '0;
         pending_q  <= 1'b0;
         active_q   <= 1'b0;
         cpu_clk_q  <= 1'b0;
         rise_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         half_cnt_q <= half_cnt_d;
         pending_q  <= pending_d;
         active_q   <= active_d;
         cpu_clk_q  <= cpu_clk_d;
         rise_q     <= rise_d;
         count_q    <= count_d;
      end
   end

   assign bus.cpu_clk      = cpu_clk_q;
   assign bus.cpu_clk_rise = rise_q;
   assign bus.rise_count   = count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl. Instance A uses the nominal step width; instance B
// has a long step pulse (so presses can land inside it) and a narrow counter
// (so div_sel saturation is observable in a short run).
module tb_cpu_clk_ctrl;

   localparam int unsigned DB     = 4;
   localparam int unsigned STEP_A = 4;
   localparam int unsigned STEP_B = 48;
   localparam int unsigned CW_A   = 24;
   localparam int unsigned CW_B   = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step_btn = 1'b0;
   logic       mode_auto = 1'b0;
   logic [4:0] div_sel = 5'd0;
   logic       sel_b = 1'b0;

   cpu_clk_ctrl_if bus_a ();
   cpu_clk_ctrl_if bus_b ();

   assign bus_a.step_btn  = step_btn;
   assign bus_a.mode_auto = mode_auto;
   assign bus_a.div_sel   = div_sel;
   assign bus_b.step_btn  = step_btn;
   assign bus_b.mode_auto = mode_auto;
   assign bus_b.div_sel   = div_sel;

   cpu_clk_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .STEP_HIGH_CYCLES(STEP_A),
      .CNT_WIDTH       (CW_A)
   ) u_dut_a (
      .clk(clk),
      .rst(rst),
      .bus(bus_a)
   );

   cpu_clk_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .STEP_HIGH_CYCLES(STEP_B),
      .CNT_WIDTH       (CW_B)
   ) u_dut_b (
      .clk(clk),
      .rst(rst),
      .bus(bus_b)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Observed instance
   logic        m_clk, m_rise;
   logic [15:0] m_count;
   always_comb begin
      m_clk   = sel_b ? bus_b.cpu_clk : bus_a.cpu_clk;
      m_rise  = sel_b ? bus_b.cpu_clk_rise : bus_a.cpu_clk_rise;
      m_count = sel_b ? bus_b.rise_count : bus_a.rise_count;
   end

   // Waveform monitor: completed high runs, low gaps between pulses, rise pulses
   int mon_rises = 0;
   int cur_hi = 0;
   int cur_lo = 0;
   bit seen = 1'b0;
   int hi_runs[$];
   int lo_runs[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (m_rise) mon_rises++;
         if (m_clk) begin
            if (seen && cur_lo > 0) lo_runs.push_back(cur_lo);
            cur_lo = 0;
            cur_hi++;
            seen = 1'b1;
         end else begin
            if (cur_hi > 0) hi_runs.push_back(cur_hi);
            cur_hi = 0;
            if (seen) cur_lo++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_rises = 0;
      cur_hi    = 0;
      cur_lo    = 0;
      seen      = 1'b0;
      hi_runs.delete();
      lo_runs.delete();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      step_btn = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_rise(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (m_rise) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic press(input int hold);
      step_btn = 1'b1;
      repeat (hold) tick();
      step_btn = 1'b0;
   endtask

   task automatic test_reset();
      sel_b     = 1'b0;
      mode_auto = 1'b0;
      rst       = 1'b1;
      tick();
      n_total++;
      if (bus_a.cpu_clk !== 1'b0) $display("FAIL reset_cpu_clk: got %b expected 0", bus_a.cpu_clk);
      else n_pass++;
      n_total++;
      if (bus_a.cpu_clk_rise !== 1'b0)
         $display("FAIL reset_rise: got %b expected 0", bus_a.cpu_clk_rise);
      else n_pass++;
      n_total++;
      if (bus_a.rise_count !== 16'd0)
         $display("FAIL reset_count: got %0d expected 0", bus_a.rise_count);
      else n_pass++;
      n_total++;
      if (bus_b.cpu_clk !== 1'b0) $display("FAIL reset_cpu_clk_b: got %b expected 0", bus_b.cpu_clk);
      else n_pass++;
   endtask

   task automatic test_auto();
      bit ok;
      int ds, p, h;
      sel_b = 1'b0;
      for (int it = 0; it < 4; it++) begin
         ds = (it == 0) ? 2 : int'($urandom_range(0, 4));
         p  = (it == 0) ? 10 : int'($urandom_range(3, 6));
         h  = 1 << ds;
         mode_auto = 1'b1;
         div_sel   = 5'(ds);
         do_reset();
         wait_rise(300, ok);
         n_total++;
         if (!ok) $display("FAIL auto_first_rise ds=%0d: got none expected rise", ds);
         else n_pass++;
         n_total++;
         if (int'(m_count) !== 1) $display("FAIL auto_first_count: got %0d expected 1", m_count);
         else n_pass++;
         mon_clear();
         repeat (p * 2 * h) tick();
         n_total++;
         if (mon_rises !== p) $display("FAIL auto_rises ds=%0d: got %0d expected %0d", ds, mon_rises, p);
         else n_pass++;
         n_total++;
         if (hi_runs.size() !== p)
            $display("FAIL auto_hi_n ds=%0d: got %0d expected %0d", ds, hi_runs.size(), p);
         else n_pass++;
         foreach (hi_runs[i]) begin
            n_total++;
            if (hi_runs[i] !== h) $display("FAIL auto_high ds=%0d: got %0d expected %0d", ds, hi_runs[i], h);
            else n_pass++;
         end
         foreach (lo_runs[i]) begin
            n_total++;
            if (lo_runs[i] !== h) $display("FAIL auto_low ds=%0d: got %0d expected %0d", ds, lo_runs[i], h);
            else n_pass++;
         end
         n_total++;
         if (m_rise !== 1'b1) $display("FAIL auto_period_end ds=%0d: got %b expected 1", ds, m_rise);
         else n_pass++;
         n_total++;
         if (int'(m_count) !== p + 1)
            $display("FAIL auto_count ds=%0d: got %0d expected %0d", ds, m_count, p + 1);
         else n_pass++;
      end
   endtask

   task automatic test_step_clean();
      sel_b     = 1'b0;
      mode_auto = 1'b0;
      div_sel   = 5'd0;
      do_reset();
      mon_clear();
      press(20);
      repeat (40) tick();
      n_total++;
      if (mon_rises !== 1) $display("FAIL step_clean_rises: got %0d expected 1", mon_rises);
      else n_pass++;
      n_total++;
      if (hi_runs.size() !== 1) $display("FAIL step_clean_pulses: got %0d expected 1", hi_runs.size());
      else n_pass++;
      foreach (hi_runs[i]) begin
         n_total++;
         if (hi_runs[i] !== STEP_A) $display("FAIL step_clean_high: got %0d expected %0d", hi_runs[i], STEP_A);
         else n_pass++;
      end
      n_total++;
      if (int'(m_count) !== 1) $display("FAIL step_clean_count: got %0d expected 1", m_count);
      else n_pass++;
   endtask

   task automatic test_step_random();
      int k;
      sel_b     = 1'b0;
      mode_auto = 1'b0;
      do_reset();
      mon_clear();
      k = int'($urandom_range(2, 4));
      for (int i = 0; i < k; i++) begin
         press(int'($urandom_range(8, 20)));
         repeat (int'($urandom_range(12, 25))) tick();
      end
      repeat (30) tick();
      n_total++;
      if (mon_rises !== k) $display("FAIL step_rand_rises: got %0d expected %0d", mon_rises, k);
      else n_pass++;
      foreach (hi_runs[i]) begin
         n_total++;
         if (hi_runs[i] !== STEP_A) $display("FAIL step_rand_high: got %0d expected %0d", hi_runs[i], STEP_A);
         else n_pass++;
      end
      n_total++;
      if (int'(m_count) !== k) $display("FAIL step_rand_count: got %0d expected %0d", m_count, k);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int p;
      sel_b     = 1'b0;
      mode_auto = 1'b0;
      for (int it = 0; it < 3; it++) begin
         p = (it == 0) ? 2 : int'($urandom_range(1, 3));
         do_reset();
         mon_clear();
         for (int c = 0; c < 12; c++) begin
            step_btn = ((c / p) % 2 == 0);
            tick();
         end
         step_btn = 1'b1;
         repeat (20) tick();
         step_btn = 1'b0;
         repeat (30) tick();
         n_total++;
         if (mon_rises !== 1) $display("FAIL bounce_rises p=%0d: got %0d expected 1", p, mon_rises);
         else n_pass++;
         n_total++;
         if (int'(m_count) !== 1) $display("FAIL bounce_count p=%0d: got %0d expected 1", p, m_count);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      sel_b     = 1'b1;
      mode_auto = 1'b0;
      do_reset();
      mon_clear();
      press(8);
      repeat (8) tick();
      press(8);
      repeat (8) tick();
      press(8);
      repeat (110) tick();
      n_total++;
      if (mon_rises !== 2) $display("FAIL b2b_rises: got %0d expected 2", mon_rises);
      else n_pass++;
      n_total++;
      if (hi_runs.size() !== 2) $display("FAIL b2b_pulses: got %0d expected 2", hi_runs.size());
      else n_pass++;
      foreach (hi_runs[i]) begin
         n_total++;
         if (hi_runs[i] !== STEP_B) $display("FAIL b2b_high: got %0d expected %0d", hi_runs[i], STEP_B);
         else n_pass++;
      end
      n_total++;
      if (lo_runs.size() !== 1) $display("FAIL b2b_gaps: got %0d expected 1", lo_runs.size());
      else n_pass++;
      foreach (lo_runs[i]) begin
         n_total++;
         if (lo_runs[i] !== 1) $display("FAIL b2b_low_gap: got %0d expected 1", lo_runs[i]);
         else n_pass++;
      end
      n_total++;
      if (int'(m_count) !== 2) $display("FAIL b2b_count: got %0d expected 2", m_count);
      else n_pass++;
      sel_b = 1'b0;
   endtask

   task automatic test_mode_switch();
      bit ok;
      sel_b     = 1'b0;
      mode_auto = 1'b1;
      div_sel   = 5'd3;
      do_reset();
      wait_rise(300, ok);
      n_total++;
      if (!ok) $display("FAIL switch_first_rise: got none expected rise");
      else n_pass++;
      mon_clear();
      mode_auto = 1'b0;
      repeat (60) tick();
      n_total++;
      if (mon_rises !== 1) $display("FAIL switch_rises: got %0d expected 1", mon_rises);
      else n_pass++;
      n_total++;
      if (hi_runs.size() !== 1) $display("FAIL switch_pulses: got %0d expected 1", hi_runs.size());
      else n_pass++;
      foreach (hi_runs[i]) begin
         n_total++;
         if (hi_runs[i] !== 8) $display("FAIL switch_full_high: got %0d expected 8", hi_runs[i]);
         else n_pass++;
      end
      press(8);
      repeat (30) tick();
      n_total++;
      if (mon_rises !== 2) $display("FAIL switch_step_rises: got %0d expected 2", mon_rises);
      else n_pass++;
      n_total++;
      if (hi_runs.size() !== 2) $display("FAIL switch_step_pulses: got %0d expected 2", hi_runs.size());
      else if (hi_runs[1] !== STEP_A)
         $display("FAIL switch_step_high: got %0d expected %0d", hi_runs[1], STEP_A);
      else n_pass++;
      n_total++;
      if (int'(m_count) !== 2) $display("FAIL switch_count: got %0d expected 2", m_count);
      else n_pass++;
   endtask

   task automatic test_reset_in_high();
      bit ok;
      sel_b     = 1'b0;
      mode_auto = 1'b0;
      do_reset();
      step_btn = 1'b1;
      wait_rise(40, ok);
      n_total++;
      if (!ok) $display("FAIL rst_high_rise: got none expected rise");
      else n_pass++;
      tick();
      n_total++;
      if (bus_a.cpu_clk !== 1'b1) $display("FAIL rst_high_pre: got %b expected 1", bus_a.cpu_clk);
      else n_pass++;
      rst      = 1'b1;
      step_btn = 1'b0;
      #1;
      n_total++;
      if (bus_a.cpu_clk !== 1'b0) $display("FAIL rst_high_clk: got %b expected 0", bus_a.cpu_clk);
      else n_pass++;
      n_total++;
      if (bus_a.rise_count !== 16'd0) $display("FAIL rst_high_count: got %0d expected 0", bus_a.rise_count);
      else n_pass++;
      repeat (2) tick();
      rst = 1'b0;
      mon_clear();
      repeat (40) tick();
      n_total++;
      if (mon_rises !== 0) $display("FAIL rst_high_no_pulse: got %0d expected 0", mon_rises);
      else n_pass++;
      press(8);
      repeat (30) tick();
      n_total++;
      if (int'(m_count) !== 1) $display("FAIL rst_high_new_press: got %0d expected 1", m_count);
      else n_pass++;
   endtask

   task automatic test_saturate();
      bit ok;
      sel_b     = 1'b1;
      mode_auto = 1'b1;
      div_sel   = 5'd31;
      do_reset();
      wait_rise(300, ok);
      n_total++;
      if (!ok) $display("FAIL sat_first_rise: got none expected rise");
      else n_pass++;
      mon_clear();
      repeat (3 * 2 * (1 << (CW_B - 1))) tick();
      n_total++;
      if (mon_rises !== 3) $display("FAIL sat_rises: got %0d expected 3", mon_rises);
      else n_pass++;
      foreach (hi_runs[i]) begin
         n_total++;
         if (hi_runs[i] !== (1 << (CW_B - 1)))
            $display("FAIL sat_high: got %0d expected %0d", hi_runs[i], 1 << (CW_B - 1));
         else n_pass++;
      end
      foreach (lo_runs[i]) begin
         n_total++;
         if (lo_runs[i] !== (1 << (CW_B - 1)))
            $display("FAIL sat_low: got %0d expected %0d", lo_runs[i], 1 << (CW_B - 1));
         else n_pass++;
      end
      n_total++;
      if (m_rise !== 1'b1) $display("FAIL sat_period_end: got %b expected 1", m_rise);
      else n_pass++;
      // Nominal instance has a 2^23 half-period and cannot have risen yet
      n_total++;
      if (bus_a.rise_count !== 16'd0) $display("FAIL sat_wide_count: got %0d expected 0", bus_a.rise_count);
      else n_pass++;
      sel_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_auto();
      test_step_clean();
      test_step_random();
      test_bounce();
      test_back_to_back();
      test_mode_switch();
      test_reset_in_high();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
